tl_mem_responder: RTL

//  TileLink-UL(+burst) slave memory model/responder: the responder end of the tilelink_if master ports driven by

---
 rtl/tl_pkg.sv | 36 +++
 rtl/tilelink_if.sv | 37 +++
 rtl/tl_sram_bank.sv | 25 ++
 rtl/tl_mem_responder.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/tl_pkg.sv
// Shared TileLink-UL types: channel opcodes, source width, beat headers and
// the size-alignment helper used by the responder.
package tl_pkg;

  localparam int SRC_W = 4;

  typedef enum logic [2:0] {
    A_PUT_FULL    = 3'd0,
    A_PUT_PARTIAL = 3'd1,
    A_GET         = 3'd4
  } tl_a_opcode_e;

  typedef enum logic [2:0] {
    D_ACCESS_ACK      = 3'd0,
    D_ACCESS_ACK_DATA = 3'd1
  } tl_d_opcode_e;

  // Header fields of an A beat (data/mask travel separately, their width is a parameter)
  typedef struct packed {
    logic [2:0]       opcode;
    logic [2:0]       size;
    logic [SRC_W-1:0] source;
    logic [31:0]      address;
  } tl_a_beat_t;

  typedef struct packed {
    tl_d_opcode_e     opcode;
    logic [2:0]       size;
    logic [SRC_W-1:0] source;
  } tl_d_beat_t;

  function automatic logic [31:0] tl_align(input logic [31:0] addr, input logic [2:0] size);
    return addr & ~((32'd1 << size) - 32'd1);
  endfunction

endpackage

// File: rtl/tilelink_if.sv
// TileLink-UL A/D channel bundle; m = requester side, s = responder side.
interface tilelink_if #(
  parameter int BEAT_BYTES = 8
);
  logic                      a_valid;
  logic                      a_ready;
  logic [2:0]                a_opcode;
  logic [2:0]                a_size;
  logic [tl_pkg::SRC_W-1:0]  a_source;
  logic [31:0]               a_address;
  logic [BEAT_BYTES-1:0]     a_mask;
  logic [8*BEAT_BYTES-1:0]   a_data;

  logic                      d_valid;
  logic                      d_ready;
  logic [2:0]                d_opcode;
  logic [2:0]                d_size;
  logic [tl_pkg::SRC_W-1:0]  d_source;
  logic [8*BEAT_BYTES-1:0]   d_data;
  logic                      d_denied;
  logic                      d_corrupt;

  modport m (
    output a_valid, a_opcode, a_size, a_source, a_address, a_mask, a_data,
    input  a_ready,
    input  d_valid, d_opcode, d_size, d_source, d_data, d_denied, d_corrupt,
    output d_ready
  );

  modport s (
    input  a_valid, a_opcode, a_size, a_source, a_address, a_mask, a_data,
    output a_ready,
    output d_valid, d_opcode, d_size, d_source, d_data, d_denied, d_corrupt,
    input  d_ready
  );

endinterface

// File: rtl/tl_sram_bank.sv
// Single-port beat-wide byte array: combinational read of the addressed row,
// per-byte masked write on posedge.
module tl_sram_bank #(
  parameter int ROWS       = 8192,
  parameter int BEAT_BYTES = 8
) (
  input  logic                      clk,
  input  logic [$clog2(ROWS)-1:0]   i_row,
  input  logic                      i_we,
  input  logic [BEAT_BYTES-1:0]     i_mask,
  input  logic [8*BEAT_BYTES-1:0]   i_wdata,
  output logic [8*BEAT_BYTES-1:0]   o_rdata
);

  logic [BEAT_BYTES-1:0][7:0] r_mem [ROWS];

  assign o_rdata = r_mem[i_row];

  always_ff @(posedge clk) begin
    for (int b = 0; b < BEAT_BYTES; b++) begin
      if (i_we && i_mask[b]) r_mem[i_row][b] <= i_wdata[8*b +: 8];
    end
  end

endmodule

// File: rtl/tl_mem_responder.sv
// TileLink-UL slave memory responder: one transaction in flight, multi-beat bursts.
// Optional macro TL_RESP_DENIED_EN: out-of-window accesses are denied instead of wrapping.
module tl_mem_responder
  import tl_pkg::*;
#(
  parameter int          MEM_BYTES  = 65536,
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
  parameter int          BEAT_BYTES = 8,
  parameter int          MAX_SIZE   = 6
) (
  input  logic  clk,
  input  logic  rst,
  tilelink_if.s if_tl
);

  localparam int         LBB    = $clog2(BEAT_BYTES);
  localparam int         AW     = $clog2(MEM_BYTES);
  localparam int         RW     = AW - LBB;
  localparam int         DW     = 8 * BEAT_BYTES;
  localparam int         BCW    = (MAX_SIZE > LBB) ? (MAX_SIZE - LBB) : 1;
  localparam logic [2:0] LBB3   = 3'(LBB);
  localparam logic [2:0] MAX_SZ = 3'(MAX_SIZE);

  typedef enum logic [1:0] {S_IDLE, S_RDATA, S_WBURST, S_WACK} state_e;

  state_e          r_state, w_state_nxt;
  tl_a_beat_t      r_req;
  tl_d_beat_t      r_d;
  logic [DW-1:0]   r_d_data;
  logic [BCW-1:0]  r_beat, r_last;
  logic            r_denied;

  logic            w_a_ready, w_d_valid, w_a_fire, w_d_fire;
  logic            w_get, w_put, w_size_ok;
  logic [BCW-1:0]  w_a_last, w_beat_sel;
  logic [31:0]     w_a_base, w_base, w_addr, w_off;
  logic [RW-1:0]   w_row;
  logic            w_oob, w_we;
  logic [BEAT_BYTES-1:0] w_wmask;
  logic [DW-1:0]   w_rdata;

  function automatic logic [BCW-1:0] beats_last(input logic [2:0] size);
    if (size <= LBB3) return '0;
    return BCW'((32'd1 << (size - LBB3)) - 32'd1);
  endfunction

  assign w_a_fire  = if_tl.a_valid && w_a_ready;
  assign w_d_fire  = w_d_valid && if_tl.d_ready;
  assign w_get     = (if_tl.a_opcode == A_GET);
  assign w_put     = (if_tl.a_opcode == A_PUT_FULL) || (if_tl.a_opcode == A_PUT_PARTIAL);
  assign w_size_ok = (if_tl.a_size <= MAX_SZ);
  assign w_a_base  = tl_align(if_tl.a_address, if_tl.a_size);
  assign w_a_last  = beats_last(if_tl.a_size);

  // RDATA prefetches the following beat so it is ready the edge the current one fires
  always_comb begin
    w_beat_sel = r_beat;
    if (r_state == S_IDLE)       w_beat_sel = '0;
    else if (r_state == S_RDATA) w_beat_sel = r_beat + BCW'(1);
  end

  assign w_base = (r_state == S_IDLE) ? w_a_base : r_req.address;
  assign w_addr = w_base + (32'(w_beat_sel) << LBB);
  assign w_off  = w_addr - BASE_ADDR;
  assign w_row  = w_off[AW-1:LBB];

`ifdef TL_RESP_DENIED_EN
  assign w_oob = (w_off >= 32'(MEM_BYTES));
`else
  logic w_unused;
  assign w_oob    = 1'b0;
  assign w_unused = ^{w_off[31:AW], w_off[LBB-1:0]};
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_a_ready   = 1'b0;
    w_d_valid   = 1'b0;
    w_we        = 1'b0;
    w_wmask     = if_tl.a_mask;
    case (r_state)
      S_IDLE: begin
        w_a_ready = 1'b1;
        w_we      = w_a_fire && w_put && w_size_ok && !w_oob;
        if (if_tl.a_opcode == A_PUT_FULL) w_wmask = '1;
        if (w_a_fire) begin
          if (w_get && w_size_ok)                      w_state_nxt = S_RDATA;
          else if (w_put && w_size_ok && w_a_last != 0) w_state_nxt = S_WBURST;
          else                                         w_state_nxt = S_WACK;
        end
      end
      S_RDATA: begin
        w_d_valid = 1'b1;
        if (w_d_fire && r_beat == r_last) w_state_nxt = S_IDLE;
      end
      S_WBURST: begin
        w_a_ready = 1'b1;
        w_we      = w_a_fire && !w_oob;
        if (r_req.opcode == A_PUT_FULL) w_wmask = '1;
        if (w_a_fire && r_beat == r_last) w_state_nxt = S_WACK;
      end
      S_WACK: begin
        w_d_valid = 1'b1;
        if (w_d_fire) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_req    <= '0;
      r_d      <= '0;
      r_d_data <= '0;
      r_beat   <= '0;
      r_last   <= '0;
      r_denied <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: if (w_a_fire) begin
          r_req.opcode  <= if_tl.a_opcode;
          r_req.size    <= if_tl.a_size;
          r_req.source  <= if_tl.a_source;
          r_req.address <= w_a_base;
          r_d.size      <= if_tl.a_size;
          r_d.source    <= if_tl.a_source;
          r_last        <= w_a_last;
          r_denied      <= w_oob;
          if (w_get && w_size_ok) begin
            r_d.opcode <= D_ACCESS_ACK_DATA;
            r_d_data   <= w_oob ? '0 : w_rdata;
            r_beat     <= '0;
          end else begin
            r_d.opcode <= D_ACCESS_ACK;
            r_d_data   <= '0;
            r_beat     <= BCW'(1);
          end
        end
        S_RDATA: if (w_d_fire && r_beat != r_last) begin
          r_beat   <= r_beat + BCW'(1);
          r_d_data <= w_oob ? '0 : w_rdata;
          r_denied <= w_oob;
        end
        S_WBURST: if (w_a_fire) begin
          r_beat <= r_beat + BCW'(1);
          if (w_oob) r_denied <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  tl_sram_bank #(
    .ROWS       (MEM_BYTES / BEAT_BYTES),
    .BEAT_BYTES (BEAT_BYTES)
  ) u_bank (
    .clk     (clk),
    .i_row   (w_row),
    .i_we    (w_we),
    .i_mask  (w_wmask),
    .i_wdata (if_tl.a_data),
    .o_rdata (w_rdata)
  );

  assign if_tl.a_ready   = w_a_ready;
  assign if_tl.d_valid   = w_d_valid;
  assign if_tl.d_opcode  = r_d.opcode;
  assign if_tl.d_size    = r_d.size;
  assign if_tl.d_source  = r_d.source;
  assign if_tl.d_data    = r_d_data;
  assign if_tl.d_denied  = r_denied;
  assign if_tl.d_corrupt = r_denied && (r_d.opcode == D_ACCESS_ACK_DATA);

`ifndef SYNTHESIS
  a_burst_hdr: assert property (@(posedge clk) disable iff (!rst)
    (r_state == S_WBURST && if_tl.a_valid) |->
      (if_tl.a_opcode == r_req.opcode && if_tl.a_source == r_req.source && if_tl.a_size == r_req.size));
  a_addr_align: assert property (@(posedge clk) disable iff (!rst)
    (r_state == S_IDLE && if_tl.a_valid) |-> (if_tl.a_address == w_a_base));
`endif

endmodule
